// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache, one word per line.
// Blocking: one request in flight, tracked by a five-state miss/fill FSM.
module dm_cache #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              op_in,
    input  logic [DATA_W-1:0] write_data_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              flush_in,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_op,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MREQ,
        S_MWAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  hit_q;
    logic [CNT_W-1:0]  miss_q;
    logic [LINES-1:0]  valid_q;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  line_tag_q;
    logic [DATA_W-1:0] line_data_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              accept;
    logic              hit;
    logic              fill;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wdata;

    assign idx    = addr_q[IDX_W-1:0];
    assign tag    = addr_q[ADDR_W-1:IDX_W];
    assign accept = valid_in & ready_in;
    assign hit    = valid_q[idx] & (line_tag_q == tag);
    assign fill   = (state_q == S_MWAIT) & mem_resp_valid & ~op_q;

    // The tag is rewritten on write hits too; it equals the stored tag there.
    assign arr_we    = fill | ((state_q == S_CHECK) & op_q & hit);
    assign arr_wdata = op_q ? wdata_q : mem_resp_data;

    assign valid_out     = (state_q == S_RESP);
    assign data_out      = rdata_q;
    assign mem_req_valid = (state_q == S_MREQ);
    assign mem_req_op    = op_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_data  = wdata_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;

    always_comb begin
        state_d  = state_q;
        ready_in = (state_q == S_IDLE) & ~flush_in & ~rst;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CHECK;
            S_CHECK: state_d = (~op_q & hit) ? S_RESP : S_MREQ;
            S_MREQ:  if (mem_req_ready) state_d = S_MWAIT;
            S_MWAIT: if (mem_resp_valid) state_d = S_RESP;
            S_RESP:  if (ready_out) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= addr_in;
                op_q    <= op_in;
                wdata_q <= write_data_in;
            end
            if (state_q == S_CHECK) begin
                if (hit) begin
                    if (hit_q != '1) hit_q <= hit_q + CNT_ONE;
                    if (!op_q) rdata_q <= line_data_q;
                end else if (miss_q != '1) begin
                    miss_q <= miss_q + CNT_ONE;
                end
            end
            if ((state_q == S_MWAIT) && mem_resp_valid)
                rdata_q <= op_q ? wdata_q : mem_resp_data;
        end
    end

    // Valid bits live in flops so reset and flush can clear them all at once.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    valid_q[gi] <= 1'b0;
                else if ((state_q == S_IDLE) && flush_in)
                    valid_q[gi] <= 1'b0;
                else if (fill && (idx == IDX_W'(gi)))
                    valid_q[gi] <= 1'b1;
            end
        end
    endgenerate

    // Tag/data arrays are block-RAM style: read is registered at acceptance.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= arr_wdata;
        end
        if (accept) begin
            line_tag_q  <= tag_mem[addr_in[IDX_W-1:0]];
            line_data_q <= data_mem[addr_in[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: a 16-bit-counter instance carries the checks,
// and a twin with 2-bit counters sees identical stimulus to show saturation.
module tb_dm_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, op_in, ready_out, flush_in;
    logic [31:0] addr_in, write_data_in;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_resp_data;

    logic        ready_in, valid_out, mem_req_valid, mem_req_op;
    logic [31:0] data_out, mem_req_addr, mem_req_data;
    logic [15:0] hit_count, miss_count;

    logic        d2_ready_in, d2_valid_out, d2_mem_req_valid, d2_mem_req_op;
    logic [31:0] d2_data_out, d2_mem_req_addr, d2_mem_req_data;
    logic [1:0]  d2_hit_count, d2_miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_cache #(.ADDR_W(32), .DATA_W(32), .LINES(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .addr_in(addr_in), .op_in(op_in), .write_data_in(write_data_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .flush_in(flush_in), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_op(mem_req_op),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    dm_cache #(.ADDR_W(32), .DATA_W(32), .LINES(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(d2_ready_in),
        .addr_in(addr_in), .op_in(op_in), .write_data_in(write_data_in),
        .valid_out(d2_valid_out), .ready_out(ready_out), .data_out(d2_data_out),
        .flush_in(flush_in), .mem_req_valid(d2_mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_op(d2_mem_req_op),
        .mem_req_addr(d2_mem_req_addr), .mem_req_data(d2_mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(d2_hit_count), .miss_count(d2_miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int hits, input int misses);
        chk({tag, ".hit_count"}, {16'h0, hit_count}, hits);
        chk({tag, ".miss_count"}, {16'h0, miss_count}, misses);
    endtask

    // One full request from IDLE back to IDLE, acting as memory when asked.
    task automatic req(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_mem,
                       input logic [31:0] mrd, input logic [31:0] exp_data,
                       input int hold_req, input int hold_resp, input logic flush_wait);
        int n = 0;
        logic saw_mem = 1'b0;
        while (!ready_in && n < 50) begin @(negedge clk); n++; end
        chk({tag, ".ready_in"}, {31'h0, ready_in}, 32'h1);
        valid_in = 1'b1; addr_in = a; op_in = op; write_data_in = wd;
        @(negedge clk);
        valid_in = 1'b0;
        n = 0;
        while (!valid_out && n < 50) begin
            if (mem_req_valid && !saw_mem) begin
                saw_mem = 1'b1;
                chk({tag, ".mem_op"}, {31'h0, mem_req_op}, {31'h0, op});
                chk({tag, ".mem_addr"}, mem_req_addr, a);
                if (op) chk({tag, ".mem_data"}, mem_req_data, wd);
                for (int i = 0; i < hold_req; i++) begin
                    @(negedge clk);
                    chk({tag, ".hold_valid"}, {31'h0, mem_req_valid}, 32'h1);
                    chk({tag, ".hold_addr"}, mem_req_addr, a);
                    chk({tag, ".hold_ready_in"}, {31'h0, ready_in}, 32'h0);
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                if (flush_wait) begin
                    flush_in = 1'b1;
                    @(negedge clk);
                    flush_in = 1'b0;
                end
                mem_resp_valid = 1'b1; mem_resp_data = mrd;
                @(negedge clk);
                mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk({tag, ".mem_used"}, {31'h0, saw_mem}, {31'h0, exp_mem});
        if (!exp_mem) chk({tag, ".hit_latency"}, n, 1);
        chk({tag, ".valid_out"}, {31'h0, valid_out}, 32'h1);
        chk({tag, ".data_out"}, data_out, exp_data);
        for (int i = 0; i < hold_resp; i++) begin
            @(negedge clk);
            chk({tag, ".hold_vout"}, {31'h0, valid_out}, 32'h1);
            chk({tag, ".hold_dout"}, data_out, exp_data);
            chk({tag, ".hold_ready_in"}, {31'h0, ready_in}, 32'h0);
        end
        ready_out = 1'b1;
        @(negedge clk);
        ready_out = 1'b0;
        $display("req %s op=%0d addr=%08h data_out=%08h mem=%0d hits=%0d misses=%0d",
                 tag, op, a, data_out, saw_mem, hit_count, miss_count);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; op_in = 1'b0; ready_out = 1'b0; flush_in = 1'b0;
        addr_in = 32'h0; write_data_in = 32'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.ready_in", {31'h0, ready_in}, 32'h0);
        chk("rst.valid_out", {31'h0, valid_out}, 32'h0);
        chk("rst.mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("rst.data_out", data_out, 32'h0);
        chk_cnt("rst", 0, 0);
        rst = 1'b0;
        #1 chk("rel.ready_in", {31'h0, ready_in}, 32'h1);

        // Reset in the middle of a miss, then a late memory response.
        @(negedge clk);
        valid_in = 1'b1; addr_in = 32'h15; op_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        chk("abort.mreq", {31'h0, mem_req_valid}, 32'h1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort.mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        chk("abort.mem_req_addr", mem_req_addr, 32'h0);
        chk("abort.valid_out", {31'h0, valid_out}, 32'h0);
        chk("abort.data_out", data_out, 32'h0);
        chk("abort.ready_in", {31'h0, ready_in}, 32'h0);
        chk_cnt("abort", 0, 0);
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        $display("reset mid-MWAIT applied, late response ignored");

        req("cold15", 1'b0, 32'h15, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1'b0);
        chk_cnt("cold15", 0, 1);
        req("hit15", 1'b0, 32'h15, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        chk_cnt("hit15", 1, 1);
        for (int i = 0; i < 4; i++)
            req("rehit15", 1'b0, 32'h15, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        chk_cnt("five_hits", 5, 1);
        chk("sat.hit_count", {30'h0, d2_hit_count}, 32'h3);
        chk("sat.miss_count", {30'h0, d2_miss_count}, 32'h1);

        req("fill05", 1'b0, 32'h05, 32'h0, 1'b1, 32'h0505_0505, 32'h0505_0505, 0, 0, 1'b0);
        req("evict15", 1'b0, 32'h15, 32'h0, 1'b1, 32'hAAAA_0015, 32'hAAAA_0015, 0, 0, 1'b0);
        req("again05", 1'b0, 32'h05, 32'h0, 1'b1, 32'h0505_0505, 32'h0505_0505, 0, 0, 1'b0);
        chk_cnt("conflict", 5, 4);

        req("fill15", 1'b0, 32'h15, 32'h0, 1'b1, 32'hAAAA_0015, 32'hAAAA_0015, 0, 0, 1'b0);
        req("wrhit15", 1'b1, 32'h15, 32'h1234_5678, 1'b1, 32'hFFFF_0000, 32'h1234_5678, 0, 0, 1'b0);
        req("rdhit15", 1'b0, 32'h15, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
        req("wrmiss27", 1'b1, 32'h27, 32'h0BAD_F00D, 1'b1, 32'hFFFF_0000, 32'h0BAD_F00D, 0, 0, 1'b0);
        req("rd27", 1'b0, 32'h27, 32'h0, 1'b1, 32'h7777_7777, 32'h7777_7777, 0, 0, 1'b0);
        chk_cnt("writes", 7, 7);

        req("bp33", 1'b0, 32'h33, 32'h0, 1'b1, 32'h3333_CAFE, 32'h3333_CAFE, 5, 4, 1'b0);
        chk_cnt("bp", 7, 8);

        flush_in = 1'b1;
        #1 chk("flush.ready_in", {31'h0, ready_in}, 32'h0);
        @(negedge clk);
        flush_in = 1'b0;
        $display("flush pulsed in IDLE");
        req("fl15", 1'b0, 32'h15, 32'h0, 1'b1, 32'h1515_1515, 32'h1515_1515, 0, 0, 1'b0);
        req("fl27", 1'b0, 32'h27, 32'h0, 1'b1, 32'h2727_2727, 32'h2727_2727, 0, 0, 1'b0);
        req("fl33", 1'b0, 32'h33, 32'h0, 1'b1, 32'h3333_3333, 32'h3333_3333, 0, 0, 1'b0);
        chk_cnt("flush", 7, 11);

        req("mwflush44", 1'b0, 32'h44, 32'h0, 1'b1, 32'h4444_0044, 32'h4444_0044, 0, 0, 1'b1);
        req("hit44", 1'b0, 32'h44, 32'h0, 1'b0, 32'h0, 32'h4444_0044, 0, 0, 1'b0);
        chk_cnt("final", 8, 12);
        chk("sat.final_hit", {30'h0, d2_hit_count}, 32'h3);
        chk("sat.final_miss", {30'h0, d2_miss_count}, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
